intrfc_reg_bank: RTL

- Parametrised host-facing register bank between the UART host bridge and a user design.
- Replaces hard-wired per-register hookups with one address-decoded bus. Provides:
  - N write-only-to-design input registers, each with a valid pulse.
  - N design-driven output registers, with new-data flags.
  - A start/busy/done command handshake.
  - A pass-through memory window with fixed read latency.

---
 rtl/intrfc_pkg.sv | 23 ++
 rtl/intrfc_cmd_fsm.sv | 83 ++++++++
 rtl/intrfc_reg_bank.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/intrfc_pkg.sv
// Shared encodings for the host register bank: address spaces, CTRL offsets,
// STATUS bit positions and the command FSM state type.
package intrfc_pkg;

    localparam logic [1:0] SPACE_IN   = 2'd0;
    localparam logic [1:0] SPACE_OUT  = 2'd1;
    localparam logic [1:0] SPACE_CTRL = 2'd2;

    localparam logic [3:0] CMD_OFS    = 4'd0;
    localparam logic [3:0] STATUS_OFS = 4'd1;
    localparam logic [3:0] NEW_OFS    = 4'd2;

    localparam int ST_BUSY = 0;
    localparam int ST_ERR  = 1;
    localparam int ST_OVR  = 2;
    localparam int ST_TMO  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } cmd_state_t;

endpackage

// File: rtl/intrfc_cmd_fsm.sv
// Start/busy/done command handshake with sticky error flag.
// INTRFC_CMD_TIMEOUT_EN adds a RUN watchdog (TIMEOUT_CYC) and a sticky tmo flag.
module intrfc_cmd_fsm
    import intrfc_pkg::*;
`ifdef INTRFC_CMD_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYC = 1024
)
`endif
(
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic done,
    input  logic clr_err,
`ifdef INTRFC_CMD_TIMEOUT_EN
    input  logic clr_tmo,
    output logic tmo,
`endif
    output logic cmd_start,
    output logic busy,
    output logic err
);

    cmd_state_t state, state_nxt;
    logic       start_fire;
    logic       err_set;
    logic       expire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_start <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            cmd_start <= start_fire;
            if (err_set)
                err <= 1'b1;
            else if (clr_err)
                err <= 1'b0;
        end
    end

    // done takes priority over both a late start and the watchdog
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (done || expire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state == RUN);
        start_fire = (state == IDLE) && start;
        err_set    = (state == RUN) && start;
    end

`ifdef INTRFC_CMD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt;

    assign expire = (state == RUN) && !done && (cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            tmo <= 1'b0;
        end else begin
            cnt <= (state == RUN) ? cnt + CNT_W'(1) : '0;
            if (expire)
                tmo <= 1'b1;
            else if (clr_tmo)
                tmo <= 1'b0;
        end
    end
`else
    assign expire = 1'b0;
`endif

endmodule

// File: rtl/intrfc_reg_bank.sv
// Host-facing register bank: IN/OUT register files, CTRL space and a memory window.
// Optional macro INTRFC_CMD_TIMEOUT_EN enables the command watchdog (TIMEOUT_CYC).
module intrfc_reg_bank
    import intrfc_pkg::*;
#(
    parameter int NUM_REGS   = 8,
    parameter int DATA_W     = 32,
    parameter int MEM_ADDR_W = 9,
    parameter int ADDR_W     = 10
`ifdef INTRFC_CMD_TIMEOUT_EN
    ,parameter int TIMEOUT_CYC = 1024
`endif
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [ADDR_W-1:0]                host_addr,
    input  logic [DATA_W-1:0]                host_wdata,
    input  logic                             host_wr,
    input  logic                             host_rd,
    output logic [DATA_W-1:0]                host_rdata,
    output logic                             host_rdata_valid,
    output logic [NUM_REGS-1:0][DATA_W-1:0]  regs_in,
    output logic [NUM_REGS-1:0]              regs_in_valid_pulse,
    input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs_out,
    input  logic [NUM_REGS-1:0]              regs_out_valid,
    output logic                             cmd_start,
    input  logic                             cmd_done,
    output logic [MEM_ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]                mem_wr_data,
    output logic                             mem_wr,
    input  logic [DATA_W-1:0]                mem_rd_data
);

    logic       in_win, rd_en;
    logic [1:0] space;
    logic [3:0] idx;
    logic       in_wr, out_rd, ctrl_wr, ctrl_rd;
    logic       start, st_wr, new_rd;
    logic       busy, err, ovr, tmo;

    assign in_win = host_addr[ADDR_W-1];
    assign space  = host_addr[5:4];
    assign idx    = host_addr[3:0];
    // a write in the same cycle suppresses the read entirely
    assign rd_en  = host_rd & ~host_wr;

    assign in_wr   = host_wr & ~in_win & (space == SPACE_IN);
    assign out_rd  = rd_en   & ~in_win & (space == SPACE_OUT);
    assign ctrl_wr = host_wr & ~in_win & (space == SPACE_CTRL);
    assign ctrl_rd = rd_en   & ~in_win & (space == SPACE_CTRL);
    assign start   = ctrl_wr & (idx == CMD_OFS) & host_wdata[0];
    assign st_wr   = ctrl_wr & (idx == STATUS_OFS);
    assign new_rd  = ctrl_rd & (idx == NEW_OFS);

    assign mem_wr      = host_wr & in_win;
    assign mem_addr    = (in_win & (host_rd | host_wr)) ? host_addr[MEM_ADDR_W-1:0] : '0;
    assign mem_wr_data = mem_wr ? host_wdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_in             <= '0;
            regs_in_valid_pulse <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_in_valid_pulse[i] <= in_wr && (idx == 4'(i));
                if (in_wr && (idx == 4'(i)))
                    regs_in[i] <= host_wdata;
            end
        end
    end

    logic [NUM_REGS-1:0][DATA_W-1:0] shadow;
    logic [NUM_REGS-1:0]             new_flag, out_clr;

    always_comb begin
        out_clr = '0;
        for (int i = 0; i < NUM_REGS; i++)
            out_clr[i] = new_rd | (out_rd && (idx == 4'(i)));
    end

    // a capture always re-arms new_flag, even against a same-cycle clearing read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow   <= '0;
            new_flag <= '0;
            ovr      <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (regs_out_valid[i])
                    shadow[i] <= regs_out[i];
                new_flag[i] <= regs_out_valid[i] | (new_flag[i] & ~out_clr[i]);
            end
            if (|(regs_out_valid & new_flag))
                ovr <= 1'b1;
            else if (st_wr && host_wdata[ST_OVR])
                ovr <= 1'b0;
        end
    end

    intrfc_cmd_fsm
`ifdef INTRFC_CMD_TIMEOUT_EN
        #(.TIMEOUT_CYC(TIMEOUT_CYC))
`endif
    u_cmd_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .done      (cmd_done),
        .clr_err   (st_wr & host_wdata[ST_ERR]),
`ifdef INTRFC_CMD_TIMEOUT_EN
        .clr_tmo   (st_wr & host_wdata[ST_TMO]),
        .tmo       (tmo),
`endif
        .cmd_start (cmd_start),
        .busy      (busy),
        .err       (err)
    );

`ifndef INTRFC_CMD_TIMEOUT_EN
    assign tmo = 1'b0;
`endif

    logic [DATA_W-1:0] rd_val;

    always_comb begin
        rd_val = '0;
        case (space)
            SPACE_IN:
                for (int i = 0; i < NUM_REGS; i++)
                    if (idx == 4'(i)) rd_val = regs_in[i];
            SPACE_OUT:
                for (int i = 0; i < NUM_REGS; i++)
                    if (idx == 4'(i)) rd_val = shadow[i];
            SPACE_CTRL:
                if (idx == STATUS_OFS) begin
                    rd_val[ST_BUSY] = busy;
                    rd_val[ST_ERR]  = err;
                    rd_val[ST_OVR]  = ovr;
                    rd_val[ST_TMO]  = tmo;
                end else if (idx == NEW_OFS) begin
                    rd_val[NUM_REGS-1:0] = new_flag;
                end
            default: rd_val = '0;
        endcase
    end

    logic [DATA_W-1:0] rdata_q;
    logic              valid_q, mem_pend;

    // memory data arrives a cycle late; show it directly, then hold it in rdata_q
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q  <= '0;
            valid_q  <= 1'b0;
            mem_pend <= 1'b0;
        end else begin
            valid_q  <= rd_en;
            mem_pend <= rd_en & in_win;
            if (rd_en && !in_win)
                rdata_q <= rd_val;
            else if (mem_pend)
                rdata_q <= mem_rd_data;
        end
    end

    assign host_rdata       = mem_pend ? mem_rd_data : rdata_q;
    assign host_rdata_valid = valid_q;

endmodule
